dmem_share_ctrl: RTL and testbench
==================================

# dmem_share_ctrl

Sequencer and port arbiter for the shared data memory between the serial host link and the RISC-V core. It accepts a fixed number of operand words from the host and writes them into data memory. It then releases the core, hands it exclusive ownership of the memory port until HALT, and streams a fixed result window back to the host over a valid/ready handshake. It sits between the host serial front-end, `RISCV_TOP`'s data-memory port and the single-port `ram` instance.

## Interface
Parameters:
- `AW`, 4: data-memory word-address width.
- `LOAD_WORDS`, 8: operand words loaded per job, at addresses 0..LOAD_WORDS-1. Legal range 1..2^AW.
- `READ_BASE`, 8: first result word address.
- `READ_WORDS`, 4: result words returned per job. Legal range 1..2^AW.
- `TIMEOUT_CYCLES`, 65535: RUN watchdog limit. Used only with `DMEM_SHARE_TIMEOUT_EN`.

Ports:
- `i_Clk`  in  1  Sole clock; all logic on its rising edge.
- `i_Rst`  in  1  Synchronous, active-high reset.
- `i_host_data`  in  32  Operand word from the host.
- `i_host_valid`  in  1  Operand word present. One word is accepted per cycle while `o_host_ready` is high.
- `o_host_ready`  out  1  High only in LOAD.
- `o_res_data`  out  32  Result word to the host.
- `o_res_valid`  out  1  Result word valid.
- `i_res_ready`  in  1  Host accepts the result word.
- `o_core_run`  out  1  Core enable (drives `i_dbg_run`).
- `i_core_halt`  in  1  Core HALT.
- `i_core_addr`  in  AW  Core word address.
- `i_core_wen_n`  in  1  Core write enable, active-low.
- `i_core_be`  in  4  Core byte enables.
- `i_core_wdata`  in  32  Core write data.
- `o_core_rdata`  out  32  Read data returned to the core.
- `o_mem_addr`  out  AW  RAM address.
- `o_mem_wren`  out  1  RAM write enable, active-high.
- `o_mem_be`  out  4  RAM byte enables.
- `o_mem_wdata`  out  32  RAM write data.
- `i_mem_q`  in  32  RAM read data. Registered, one-cycle latency from the address.
- `o_state`  out  2  Current state, for debug.
- `o_timeout`  out  1  Sticky flag: last job ended by the watchdog.

## Operation
States: LOAD=0, RUN=1, RD_ADDR=2, RD_DATA=3. Counters `ld_idx` and `rd_idx`, plus the watchdog counter.

**LOAD**
- RAM port signals: `o_mem_addr`=`ld_idx`, `o_mem_wdata`=`i_host_data`, `o_mem_be`=4'b1111, `o_mem_wren`=`i_host_valid`.
- Each accepted word increments `ld_idx`.
- An accepted word with `ld_idx`==LOAD_WORDS-1 moves to RUN and clears `ld_idx` and the watchdog counter.

**RUN**
- `o_core_run`=1.
- RAM port is passed straight through: address, byte enables, write data from the core; `o_mem_wren`=~`i_core_wen_n`; `o_core_rdata`=`i_mem_q`.
- Host data is ignored.
- `i_core_halt`=1 moves to RD_ADDR next cycle. A core write in the halt cycle is still performed.

**RD_ADDR**
- `o_mem_addr`=(READ_BASE+`rd_idx`) mod 2^AW.
- `o_mem_wren`=0.
- Always moves to RD_DATA.

**RD_DATA**
- Same address as RD_ADDR, `o_mem_wren`=0.
- `o_res_valid`=1, `o_res_data`=`i_mem_q`, held stable until `i_res_ready`.
- On `i_res_ready`: if `rd_idx`==READ_WORDS-1, clear `rd_idx` and go to LOAD; otherwise increment `rd_idx` and go to RD_ADDR.

**Outside RUN**
- `o_core_rdata`=0 and `o_core_run`=0. Core write requests are blocked.

**Outside RD_DATA**
- `o_res_data`=0.

## Timing
- Reset values: state LOAD, all counters 0, `o_timeout`=0. During and after reset, `o_host_ready`=1 and every other output is 0.
- Reset mid-job aborts immediately. No RAM write occurs in a cycle where `i_Rst`=1.
- Core release: `o_core_run` rises the cycle after the last operand write.
- Result throughput: 2 cycles per word minimum. First `o_res_valid` appears 2 cycles after the halt cycle.
- `i_host_valid` outside LOAD is dropped, with no write.
- `i_res_ready` without `o_res_valid` is ignored.

## Configuration
`DMEM_SHARE_TIMEOUT_EN`:
- **Defined:** a 32-bit counter runs in RUN. When it reaches TIMEOUT_CYCLES with no HALT, the block sets `o_timeout`, drops `o_core_run` and goes to RD_ADDR. `o_timeout` clears on reset or on the next LOAD→RUN transition. HALT in the same cycle as the timeout takes priority and leaves `o_timeout`=0.
- **Not defined:** RUN waits on HALT indefinitely, and `o_timeout` is tied to 0.

## Test plan
1. Reset, then 8 host words 1..8 on consecutive cycles: RAM writes at addresses 0..7, `o_host_ready` falls and `o_core_run`=1 on the cycle after word 8.
2. In RUN, the core writes 0xDEADBEEF to address 9 with BE 4'b0011, then asserts HALT: `o_mem_wren` follows the core, and readback word 1 shows the low halfword updated.
3. Readback with `i_res_ready` held low for 5 cycles on word 0: `o_res_valid` and data stay stable. Four words from addresses 8..11 are delivered, then state returns to LOAD.
4. `i_Rst` pulsed in RUN and in RD_DATA: next cycle is LOAD, `o_core_run`=0, `o_res_valid`=0, and the next load starts at address 0.
5. With `DMEM_SHARE_TIMEOUT_EN`, TIMEOUT_CYCLES=20, HALT never asserted: RD_ADDR after 20 RUN cycles, `o_timeout`=1, cleared at the next RUN entry.

Source files
------------

// File: rtl/dmem_share_ctrl.sv
// Sequences one host job through the shared data memory: load operands, run the core, return results.
// Latency: o_core_run rises 1 cycle after the last operand write; first result is valid 2 cycles after HALT.
// Backpressure: o_host_ready is high only in LOAD; a result word is held stable in RD_DATA until i_res_ready.
//
// Ports: i_Clk/i_Rst (synchronous, active-high); host operand input (i_host_*, o_host_ready);
// result stream (o_res_*, i_res_ready); core side (o_core_run, i_core_*, o_core_rdata);
// RAM side (o_mem_*, i_mem_q with 1-cycle registered read); debug (o_state, o_timeout).
// Optional RUN watchdog: define DMEM_SHARE_TIMEOUT_EN.
module dmem_share_ctrl #(
  parameter int AW             = 4,
  parameter int LOAD_WORDS     = 8,
  parameter int READ_BASE      = 8,
  parameter int READ_WORDS     = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic          i_Clk,
  input  logic          i_Rst,
  input  logic [31:0]   i_host_data,
  input  logic          i_host_valid,
  output logic          o_host_ready,
  output logic [31:0]   o_res_data,
  output logic          o_res_valid,
  input  logic          i_res_ready,
  output logic          o_core_run,
  input  logic          i_core_halt,
  input  logic [AW-1:0] i_core_addr,
  input  logic          i_core_wen_n,
  input  logic [3:0]    i_core_be,
  input  logic [31:0]   i_core_wdata,
  output logic [31:0]   o_core_rdata,
  output logic [AW-1:0] o_mem_addr,
  output logic          o_mem_wren,
  output logic [3:0]    o_mem_be,
  output logic [31:0]   o_mem_wdata,
  input  logic [31:0]   i_mem_q,
  output logic [1:0]    o_state,
  output logic          o_timeout
);

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_RUN     = 2'd1,
    ST_RD_ADDR = 2'd2,
    ST_RD_DATA = 2'd3
  } state_e;

  localparam logic [AW-1:0] LD_LAST = AW'(LOAD_WORDS - 1);
  localparam logic [AW-1:0] RD_LAST = AW'(READ_WORDS - 1);
  localparam logic [AW-1:0] RD_BASE = AW'(READ_BASE);

  state_e        state_q, state_d;
  logic [AW-1:0] ld_idx_q, ld_idx_d;
  logic [AW-1:0] rd_idx_q, rd_idx_d;

`ifdef DMEM_SHARE_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] wd_q, wd_d;
  logic        timeout_q, timeout_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

  // Next-state and counter logic
  always_comb begin
    state_d  = state_q;
    ld_idx_d = ld_idx_q;
    rd_idx_d = rd_idx_q;
`ifdef DMEM_SHARE_TIMEOUT_EN
    wd_d      = wd_q;
    timeout_d = timeout_q;
`endif
    case (state_q)
      ST_LOAD: begin
        if (i_host_valid) begin
          if (ld_idx_q == LD_LAST) begin
            state_d  = ST_RUN;
            ld_idx_d = '0;
`ifdef DMEM_SHARE_TIMEOUT_EN
            wd_d      = '0;
            timeout_d = 1'b0;
`endif
          end else begin
            ld_idx_d = ld_idx_q + 1'b1;
          end
        end
      end
      ST_RUN: begin
`ifdef DMEM_SHARE_TIMEOUT_EN
        wd_d = wd_q + 32'd1;
        // HALT wins over a coincident watchdog expiry, leaving the flag clear.
        if (i_core_halt) begin
          state_d = ST_RD_ADDR;
        end else if (wd_q == TMO_LAST) begin
          state_d   = ST_RD_ADDR;
          timeout_d = 1'b1;
        end
`else
        if (i_core_halt) state_d = ST_RD_ADDR;
`endif
      end
      ST_RD_ADDR: state_d = ST_RD_DATA;
      ST_RD_DATA: begin
        if (i_res_ready) begin
          if (rd_idx_q == RD_LAST) begin
            state_d  = ST_LOAD;
            rd_idx_d = '0;
          end else begin
            state_d  = ST_RD_ADDR;
            rd_idx_d = rd_idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q  <= ST_LOAD;
      ld_idx_q <= '0;
      rd_idx_q <= '0;
`ifdef DMEM_SHARE_TIMEOUT_EN
      wd_q      <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ld_idx_q <= ld_idx_d;
      rd_idx_q <= rd_idx_d;
`ifdef DMEM_SHARE_TIMEOUT_EN
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  // Port mux. Reset overrides everything combinationally so an abort never
  // lets a write through and the outputs already show the idle LOAD view.
  always_comb begin
    o_host_ready = 1'b0;
    o_res_data   = '0;
    o_res_valid  = 1'b0;
    o_core_run   = 1'b0;
    o_core_rdata = '0;
    o_mem_addr   = '0;
    o_mem_wren   = 1'b0;
    o_mem_be     = '0;
    o_mem_wdata  = '0;
    o_state      = state_q;
    case (state_q)
      ST_LOAD: begin
        o_host_ready = 1'b1;
        o_mem_addr   = ld_idx_q;
        o_mem_wdata  = i_host_data;
        o_mem_be     = 4'b1111;
        o_mem_wren   = i_host_valid;
      end
      ST_RUN: begin
        o_core_run   = 1'b1;
        o_mem_addr   = i_core_addr;
        o_mem_be     = i_core_be;
        o_mem_wdata  = i_core_wdata;
        o_mem_wren   = ~i_core_wen_n;
        o_core_rdata = i_mem_q;
      end
      ST_RD_ADDR: o_mem_addr = RD_BASE + rd_idx_q;
      ST_RD_DATA: begin
        // Address is held so the registered RAM output stays stable while stalled.
        o_mem_addr  = RD_BASE + rd_idx_q;
        o_res_valid = 1'b1;
        o_res_data  = i_mem_q;
      end
      default: ;
    endcase
    if (i_Rst) begin
      o_host_ready = 1'b1;
      o_res_data   = '0;
      o_res_valid  = 1'b0;
      o_core_run   = 1'b0;
      o_core_rdata = '0;
      o_mem_addr   = '0;
      o_mem_wren   = 1'b0;
      o_mem_be     = '0;
      o_mem_wdata  = '0;
      o_state      = ST_LOAD;
    end
  end

`ifdef DMEM_SHARE_TIMEOUT_EN
  assign o_timeout = timeout_q & ~i_Rst;
`else
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_share_ctrl.sv
// Directed bench for dmem_share_ctrl with a byte-enabled single-port RAM model.
// Latency: not applicable.
// Backpressure: result ready is held low on word 0 to stall the readback.
module tb_dmem_share_ctrl;

`ifdef DMEM_SHARE_TIMEOUT_EN
  localparam int TB_TMO = 20;
`else
  localparam int TB_TMO = 65535;
`endif

  logic        i_Clk = 1'b0;
  logic        i_Rst;
  logic [31:0] i_host_data;
  logic        i_host_valid;
  logic        o_host_ready;
  logic [31:0] o_res_data;
  logic        o_res_valid;
  logic        i_res_ready;
  logic        o_core_run;
  logic        i_core_halt;
  logic [3:0]  i_core_addr;
  logic        i_core_wen_n;
  logic [3:0]  i_core_be;
  logic [31:0] i_core_wdata;
  logic [31:0] o_core_rdata;
  logic [3:0]  o_mem_addr;
  logic        o_mem_wren;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_q;
  logic [1:0]  o_state;
  logic        o_timeout;

  int n_vec = 0;
  int n_err = 0;

  always #5 i_Clk = ~i_Clk;

  dmem_share_ctrl #(.TIMEOUT_CYCLES(TB_TMO)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst),
    .i_host_data(i_host_data), .i_host_valid(i_host_valid), .o_host_ready(o_host_ready),
    .o_res_data(o_res_data), .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
    .o_core_run(o_core_run), .i_core_halt(i_core_halt), .i_core_addr(i_core_addr),
    .i_core_wen_n(i_core_wen_n), .i_core_be(i_core_be), .i_core_wdata(i_core_wdata),
    .o_core_rdata(o_core_rdata), .o_mem_addr(o_mem_addr), .o_mem_wren(o_mem_wren),
    .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata), .i_mem_q(i_mem_q),
    .o_state(o_state), .o_timeout(o_timeout)
  );

  // RAM model: registered read returning the pre-write contents.
  logic [31:0] mem [16];
  logic        ram_init;
  always @(posedge i_Clk) begin
    if (ram_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'hA000_0000 + 32'(i);
    end else if (o_mem_wren) begin
      for (int b = 0; b < 4; b++)
        if (o_mem_be[b]) mem[o_mem_addr][8*b +: 8] <= o_mem_wdata[8*b +: 8];
    end
    i_mem_q <= mem[o_mem_addr];
  end

  typedef struct {
    logic        hv;   logic [31:0] hd;  logic rr;   logic halt;
    logic [3:0]  ca;   logic        cwn; logic [3:0] cbe; logic [31:0] cwd;
    logic        e_hr; logic        e_run; logic e_rv; logic [31:0] e_rd;
    logic [3:0]  e_addr; logic      e_wren; logic [1:0] e_st; logic [31:0] e_crd;
    logic        chk_w; logic [3:0] e_be; logic [31:0] e_wd;
  } vec_t;

  function automatic vec_t mk(
    input logic hv, input logic [31:0] hd, input logic rr, input logic halt,
    input logic [3:0] ca, input logic cwn, input logic [3:0] cbe, input logic [31:0] cwd,
    input logic e_hr, input logic e_run, input logic e_rv, input logic [31:0] e_rd,
    input logic [3:0] e_addr, input logic e_wren, input logic [1:0] e_st, input logic [31:0] e_crd,
    input logic chk_w, input logic [3:0] e_be, input logic [31:0] e_wd);
    vec_t t;
    t.hv = hv; t.hd = hd; t.rr = rr; t.halt = halt;
    t.ca = ca; t.cwn = cwn; t.cbe = cbe; t.cwd = cwd;
    t.e_hr = e_hr; t.e_run = e_run; t.e_rv = e_rv; t.e_rd = e_rd;
    t.e_addr = e_addr; t.e_wren = e_wren; t.e_st = e_st; t.e_crd = e_crd;
    t.chk_w = chk_w; t.e_be = e_be; t.e_wd = e_wd;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic idle_in();
    i_host_valid = 1'b0; i_host_data = '0; i_res_ready = 1'b0; i_core_halt = 1'b0;
    i_core_addr = '0; i_core_wen_n = 1'b1; i_core_be = '0; i_core_wdata = '0;
  endtask

  // Drive n consecutive host words; returns at the negedge after the last one.
  task automatic load_n(input int n, input logic [31:0] base);
    for (int k = 0; k < n; k++) begin
      idle_in();
      i_host_valid = 1'b1;
      i_host_data  = base + 32'(k);
      @(negedge i_Clk);
    end
    idle_in();
  endtask

  vec_t tbl[$];

  initial begin
    int n;
    bit ok;
    // Main job: load 1..8, core writes, halt, stalled readback of 8..11.
    tbl.push_back(mk(0, 0, 0, 0, 5, 0, 4'hF, 32'h55, 1, 0, 0, 0, 0, 0, 0, 0, 1, 4'hF, 0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1, 32'(i + 1), 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 4'(i), 1, 0, 0, 1, 4'hF, 32'(i + 1)));
    tbl.push_back(mk(1, 32'hCAFE, 0, 0, 9, 0, 4'b0011, 32'hDEADBEEF,
                     0, 1, 0, 0, 9, 1, 1, 32'hA000_0007, 1, 4'b0011, 32'hDEADBEEF));
    tbl.push_back(mk(0, 0, 0, 0, 3, 1, 4'hF, 0, 0, 1, 0, 0, 3, 0, 1, 32'hA000_0009, 1, 4'hF, 0));
    tbl.push_back(mk(0, 0, 0, 1, 10, 0, 4'b1100, 32'h1234_5678,
                     0, 1, 0, 0, 10, 1, 1, 32'd4, 1, 4'b1100, 32'h1234_5678));
    tbl.push_back(mk(1, 32'd77, 1, 0, 0, 0, 4'hF, 32'hFFFF_FFFF, 0, 0, 0, 0, 8, 0, 2, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 32'hA000_0008, 8, 0, 3, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 32'hA000_0008, 8, 0, 3, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 9, 0, 2, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 32'hA000_BEEF, 9, 0, 3, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 10, 0, 2, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 32'h1234_000A, 10, 0, 3, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 11, 0, 2, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 32'hA000_000B, 11, 0, 3, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 4'hF, 0));

    // Reset with host and core both requesting: nothing must reach the RAM.
    idle_in();
    i_Rst = 1'b1; ram_init = 1'b1;
    i_host_valid = 1'b1; i_host_data = 32'h99;
    @(negedge i_Clk);
    @(negedge i_Clk);
    #2;
    chk("rst_host_ready", 32'(o_host_ready), 1);
    chk("rst_outputs", {o_res_valid, o_core_run, o_mem_wren, o_timeout, o_state, o_mem_addr},
        32'h0);
    chk("rst_data", o_res_data | o_core_rdata | o_mem_wdata | 32'(o_mem_be), 0);
    @(negedge i_Clk);
    i_Rst = 1'b0; ram_init = 1'b0;

    foreach (tbl[v]) begin
      i_host_valid = tbl[v].hv; i_host_data = tbl[v].hd; i_res_ready = tbl[v].rr;
      i_core_halt = tbl[v].halt; i_core_addr = tbl[v].ca; i_core_wen_n = tbl[v].cwn;
      i_core_be = tbl[v].cbe; i_core_wdata = tbl[v].cwd;
      #2;
      ok = (o_host_ready === tbl[v].e_hr) && (o_core_run === tbl[v].e_run) &&
           (o_res_valid === tbl[v].e_rv) && (o_res_data === tbl[v].e_rd) &&
           (o_mem_addr === tbl[v].e_addr) && (o_mem_wren === tbl[v].e_wren) &&
           (o_state === tbl[v].e_st) && (o_core_rdata === tbl[v].e_crd) &&
           (o_timeout === 1'b0) &&
           (!tbl[v].chk_w || ((o_mem_be === tbl[v].e_be) && (o_mem_wdata === tbl[v].e_wd)));
      n_vec++;
      if (!ok) begin
        n_err++;
        $display("FAIL vec%0d: got hr=%b run=%b rv=%b rd=%h addr=%h wren=%b st=%0d crd=%h be=%h wd=%h to=%b; want hr=%b run=%b rv=%b rd=%h addr=%h wren=%b st=%0d crd=%h be=%h wd=%h",
                 v, o_host_ready, o_core_run, o_res_valid, o_res_data, o_mem_addr, o_mem_wren,
                 o_state, o_core_rdata, o_mem_be, o_mem_wdata, o_timeout,
                 tbl[v].e_hr, tbl[v].e_run, tbl[v].e_rv, tbl[v].e_rd, tbl[v].e_addr,
                 tbl[v].e_wren, tbl[v].e_st, tbl[v].e_crd, tbl[v].e_be, tbl[v].e_wd);
      end
      @(negedge i_Clk);
    end
    idle_in();

    for (int i = 0; i < 8; i++) chk($sformatf("ram_load%0d", i), mem[i], 32'(i + 1));
    chk("ram_be_halfword", mem[9], 32'hA000_BEEF);
    chk("ram_halt_write", mem[10], 32'h1234_000A);

    // Reset pulsed in RUN.
    load_n(8, 32'h100);
    chk("run_entry_state", 32'(o_state), 1);
    i_Rst = 1'b1; i_host_valid = 1'b1; i_core_wen_n = 1'b0; i_core_addr = 4'd2; i_core_be = 4'hF;
    #2;
    chk("rst_run_wren", {o_mem_wren, o_core_run, o_host_ready}, 32'b001);
    @(negedge i_Clk);
    idle_in(); i_Rst = 1'b0; i_host_valid = 1'b1; i_host_data = 32'h200;
    #2;
    chk("after_rst_run", {o_state, o_core_run, o_res_valid, o_mem_wren, o_mem_addr}, 32'h10);
    @(negedge i_Clk);
    load_n(7, 32'h201);

    // Reset pulsed in RD_DATA.
    i_core_halt = 1'b1;
    @(negedge i_Clk);
    idle_in();
    @(negedge i_Clk);
    #2;
    chk("rd_data_reached", {o_state, o_res_valid}, 32'b111);
    i_Rst = 1'b1;
    #2;
    chk("rst_rd_outputs", {o_res_valid, o_host_ready, o_state}, 32'b0100);
    chk("rst_rd_data", o_res_data, 0);
    @(negedge i_Clk);
    i_Rst = 1'b0; i_host_valid = 1'b1; i_host_data = 32'h300;
    #2;
    chk("after_rst_rd", {o_state, o_core_run, o_res_valid, o_mem_wren, o_mem_addr}, 32'h10);
    @(negedge i_Clk);
    idle_in();

`ifdef DMEM_SHARE_TIMEOUT_EN
    load_n(7, 32'h301);
    n = 0;
    while (o_state == 2'd1 && n < 100) begin
      n++;
      @(negedge i_Clk);
    end
    chk("tmo_run_cycles", 32'(n), 20);
    chk("tmo_state_flag", {o_state, o_timeout, o_core_run}, 32'b1010);
    i_res_ready = 1'b1;
    n = 0;
    while (o_state != 2'd0 && n < 20) begin
      n++;
      @(negedge i_Clk);
    end
    chk("tmo_back_to_load", 32'(o_state), 0);
    chk("tmo_sticky", 32'(o_timeout), 1);
    load_n(8, 32'h400);
    chk("tmo_cleared_run", {o_state, o_timeout, o_core_run}, 32'b0101);
    i_core_halt = 1'b1;
    @(negedge i_Clk);
    idle_in();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
